// File: rtl/fpga_config_loader_pkg.sv
// Shared definitions for the serial configuration loader: FSM state
// encoding and helpers that derive the word count and final-word bit count.
package fpga_cfg_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RST,
        FETCH,
        SHIFT_LO,
        SHIFT_HI,
        DONE
    } cfg_state_t;

    // Number of stream words needed to carry cfg_size bits.
    function automatic int calc_nwords(input int cfg_size, input int word_w);
        return (cfg_size + word_w - 1) / word_w;
    endfunction

    // Number of meaningful (upper) bits in the final stream word.
    function automatic int calc_last_bits(input int cfg_size, input int word_w);
        return cfg_size - (calc_nwords(cfg_size, word_w) - 1) * word_w;
    endfunction

endpackage

// File: rtl/fpga_config_loader_if.sv
// Valid/ready word stream feeding the configuration loader.
interface fpga_config_loader_if #(
    parameter int WORD_W = 32
) ();
    logic [WORD_W-1:0] s_data;
    logic              s_valid;
    logic              s_ready;

    modport master (output s_data, output s_valid, input s_ready);
    modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/fpga_config_loader_shifter.sv
// Word-wide parallel-in/serial-out register, MSB first. Holds pure data,
// so it carries no reset.
module cfg_word_shifter #(
    parameter int WORD_W = 32
) (
    input  logic              clk,
    input  logic              i_load,
    input  logic              i_shift,
    input  logic [WORD_W-1:0] i_data,
    output logic              o_serial
);
    logic [WORD_W-1:0] r_word;

    // Load a fresh word, or move the next bit up into the MSB position.
    always_ff @(posedge clk) begin
        if (i_load) begin
            r_word <= i_data;
        end else if (i_shift) begin
            r_word <= {r_word[WORD_W-2:0], 1'b0};
        end
    end

    assign o_serial = r_word[WORD_W-1];
endmodule

// File: rtl/fpga_config_loader.sv
// Self-timed programmer for the fabric configuration chain: pulses the chain
// reset, then serializes exactly CONFIG_SIZE bits from the word stream using a
// divide-by-2 chain clock, and reports done once the last bit is captured.
module fpga_config_loader
    import fpga_cfg_pkg::*;
#(
    parameter int CONFIG_SIZE = 1530,
    parameter int WORD_W      = 32,
    parameter int RST_CYCLES  = 4
) (
    input  logic                 config_clk,
    input  logic                 config_rst,
    input  logic                 start,
    fpga_config_loader_if.slave  s_if,
    output logic                 chain_rst,
    output logic                 chain_clk,
    output logic                 chain_data,
    output logic                 busy,
    output logic                 done
);
    localparam int BIT_CNT_W  = $clog2(CONFIG_SIZE + 1);
    localparam int WBIT_CNT_W = $clog2(WORD_W + 1);
    localparam int RST_CNT_W  = $clog2(RST_CYCLES + 1);

    cfg_state_t            r_state;
    logic [BIT_CNT_W-1:0]  r_bits_left;
    logic [WBIT_CNT_W-1:0] r_wbits_left;
    logic [RST_CNT_W-1:0]  r_rst_left;
    logic                  r_chain_rst;
    logic                  r_chain_clk;
    logic                  r_chain_data;
    logic                  r_busy;
    logic                  r_done;

    logic                  w_load;
    logic                  w_shift;
    logic                  w_serial;

    // The shifter is advanced during SHIFT_LO so that its MSB already holds
    // the following bit when SHIFT_HI decides whether to present it.
    assign w_load  = (r_state == FETCH) && s_if.s_valid;
    assign w_shift = (r_state == SHIFT_LO);

    cfg_word_shifter #(
        .WORD_W (WORD_W)
    ) u_shifter (
        .clk      (config_clk),
        .i_load   (w_load),
        .i_shift  (w_shift),
        .i_data   (s_if.s_data),
        .o_serial (w_serial)
    );

    // Sequencer: state, counters and every registered output.
    always_ff @(posedge config_clk or posedge config_rst) begin
        if (config_rst) begin
            r_state      <= IDLE;
            r_bits_left  <= '0;
            r_wbits_left <= '0;
            r_rst_left   <= '0;
            r_chain_rst  <= 1'b1;
            r_chain_clk  <= 1'b0;
            r_chain_data <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    r_chain_rst <= 1'b0;
                    r_chain_clk <= 1'b0;
                    if (start) begin
                        r_state     <= RST;
                        r_chain_rst <= 1'b1;
                        r_busy      <= 1'b1;
                        r_done      <= 1'b0;
                        r_rst_left  <= RST_CNT_W'(RST_CYCLES - 1);
                        r_bits_left <= BIT_CNT_W'(CONFIG_SIZE);
                    end
                end
                RST: begin
                    if (r_rst_left == '0) begin
                        r_state      <= FETCH;
                        r_chain_rst  <= 1'b0;
                        r_wbits_left <= WBIT_CNT_W'(WORD_W);
                    end else begin
                        r_rst_left <= r_rst_left - 1'b1;
                    end
                end
                FETCH: begin
                    r_chain_clk <= 1'b0;
                    if (s_if.s_valid) begin
                        r_state      <= SHIFT_LO;
                        r_chain_data <= s_if.s_data[WORD_W-1];
                    end
                end
                SHIFT_LO: begin
                    r_state     <= SHIFT_HI;
                    r_chain_clk <= 1'b1;
                end
                SHIFT_HI: begin
                    r_chain_clk  <= 1'b0;
                    r_bits_left  <= r_bits_left - 1'b1;
                    r_wbits_left <= r_wbits_left - 1'b1;
                    if (r_bits_left == BIT_CNT_W'(1)) begin
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else if (r_wbits_left == WBIT_CNT_W'(1)) begin
                        r_state      <= FETCH;
                        r_wbits_left <= WBIT_CNT_W'(WORD_W);
                    end else begin
                        r_state      <= SHIFT_LO;
                        r_chain_data <= w_serial;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Ready is a pure state decode; it never looks at s_valid.
    assign s_if.s_ready = (r_state == FETCH);

    assign chain_rst  = r_chain_rst;
    assign chain_clk  = r_chain_clk;
    assign chain_data = r_chain_data;
    assign busy       = r_busy;
    assign done       = r_done;
endmodule

// File: tb/tb_fpga_config_loader.sv
// Bench for fpga_config_loader: a default-size loader and a tiny 5-bit/4-bit
// loader, driven with random bitstreams and directed control events.
module tb_fpga_config_loader;

    localparam int CS  = 1530;
    localparam int WW  = 32;
    localparam int RC  = 4;
    localparam int NW  = (CS + WW - 1) / WW;
    localparam int LB  = CS - (NW - 1) * WW;
    localparam int LIMIT = 20000;

    logic clk;
    logic rst_b, rst_s;
    logic start_b, start_s;
    logic b_chain_rst, b_chain_clk, b_chain_data, b_busy, b_done;
    logic s_chain_rst, s_chain_clk, s_chain_data, s_busy, s_done;

    fpga_config_loader_if #(.WORD_W(WW)) bif ();
    fpga_config_loader_if #(.WORD_W(4))  sif ();

    fpga_config_loader #(.CONFIG_SIZE(CS), .WORD_W(WW), .RST_CYCLES(RC)) u_dut (
        .config_clk (clk),
        .config_rst (rst_b),
        .start      (start_b),
        .s_if       (bif.slave),
        .chain_rst  (b_chain_rst),
        .chain_clk  (b_chain_clk),
        .chain_data (b_chain_data),
        .busy       (b_busy),
        .done       (b_done)
    );

    fpga_config_loader #(.CONFIG_SIZE(5), .WORD_W(4), .RST_CYCLES(4)) u_small (
        .config_clk (clk),
        .config_rst (rst_s),
        .start      (start_s),
        .s_if       (sif.slave),
        .chain_rst  (s_chain_rst),
        .chain_clk  (s_chain_clk),
        .chain_data (s_chain_data),
        .busy       (s_busy),
        .done       (s_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    logic        exp_bits[$];
    logic [31:0] words[$];
    logic        cap_b[$];
    logic        cap_s[$];

    // What the fabric sees: one bit per rising chain clock.
    always @(posedge b_chain_clk) cap_b.push_back(b_chain_data);
    always @(posedge s_chain_clk) cap_s.push_back(s_chain_data);

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Random bitstream in shift order (index 0 = bitstream bit cs-1).
    task automatic rand_bits(input int cs);
        exp_bits.delete();
        for (int i = 0; i < cs; i++) exp_bits.push_back(1'($urandom_range(0, 1)));
    endtask

    // Pack the bitstream into words: first bit in word bit w-1, padding at the bottom.
    task automatic build_words(input int cs, input int w, input bit pad_ones);
        int nw;
        logic [31:0] wd;
        nw = (cs + w - 1) / w;
        words.delete();
        for (int k = 0; k < nw; k++) begin
            wd = '0;
            for (int j = 0; j < w; j++) begin
                if (k * w + j < cs) wd[w-1-j] = exp_bits[k*w+j];
                else wd[w-1-j] = pad_ones ? 1'b1 : 1'($urandom_range(0, 1));
            end
            words.push_back(wd);
        end
    endtask

    task automatic check_caps(input int sel, input string tag);
        int n, mism;
        n = (sel != 0) ? cap_s.size() : cap_b.size();
        check({tag, "_count"}, n, exp_bits.size());
        mism = 0;
        for (int i = 0; i < n && i < exp_bits.size(); i++) begin
            if (((sel != 0) ? cap_s[i] : cap_b[i]) !== exp_bits[i]) mism++;
        end
        check({tag, "_bits_wrong"}, mism, 0);
    endtask

    // Run one load from IDLE/DONE. Words are offered continuously (surplus
    // words included) except for 5 stall cycles in FETCH ahead of each listed
    // word. Optionally pulse start at a loop cycle or reset after N captures.
    task automatic run_load(input int sel, input string tag,
                            input int st0, input int st1, input int st2,
                            input int start_at, input int rst_at_bit,
                            output int busy_cyc, output int rst_cyc, output int hs);
        int widx, stall, cyc, nw, ncap;
        bit hs_pend, v, aborted;
        logic o_busy, o_rst, o_done, o_ready, o_clk, o_data;
        logic [31:0] dw;
        nw = words.size();
        widx = 0; hs_pend = 0; aborted = 0;
        busy_cyc = 0; rst_cyc = 0; hs = 0;
        stall = (st0 == 0 || st1 == 0 || st2 == 0) ? 5 : 0;
        o_done = 1'b0;
        @(negedge clk);
        cap_b.delete(); cap_s.delete();
        if (sel != 0) start_s = 1'b1; else start_b = 1'b1;
        for (cyc = 0; cyc < LIMIT; cyc++) begin
            @(negedge clk);
            o_busy  = (sel != 0) ? s_busy       : b_busy;
            o_rst   = (sel != 0) ? s_chain_rst  : b_chain_rst;
            o_done  = (sel != 0) ? s_done       : b_done;
            o_ready = (sel != 0) ? sif.s_ready  : bif.s_ready;
            ncap    = (sel != 0) ? cap_s.size() : cap_b.size();
            if (cyc == 0) begin
                check({tag, "_rst_after_start"}, o_rst, 1'b1);
                check({tag, "_done_dropped"}, o_done, 1'b0);
            end
            if (o_busy) busy_cyc++;
            if (o_rst) rst_cyc++;
            if (hs_pend) begin
                hs++;
                widx++;
                if (widx == st0 || widx == st1 || widx == st2) stall = 5;
            end
            if (o_done) break;
            if (rst_at_bit >= 0 && ncap >= rst_at_bit) begin
                aborted = 1'b1;
                if (sel != 0) begin rst_s = 1'b1; sif.s_valid = 1'b0; end
                else begin rst_b = 1'b1; bif.s_valid = 1'b0; end
                #1;
                o_clk  = (sel != 0) ? s_chain_clk  : b_chain_clk;
                o_data = (sel != 0) ? s_chain_data : b_chain_data;
                check({tag, "_arst_chain_rst"}, (sel != 0) ? s_chain_rst : b_chain_rst, 1'b1);
                check({tag, "_arst_chain_clk"}, o_clk, 1'b0);
                check({tag, "_arst_chain_data"}, o_data, 1'b0);
                check({tag, "_arst_busy"}, (sel != 0) ? s_busy : b_busy, 1'b0);
                check({tag, "_arst_ready"}, (sel != 0) ? sif.s_ready : bif.s_ready, 1'b0);
                @(negedge clk);
                if (sel != 0) rst_s = 1'b0; else rst_b = 1'b0;
                bif.s_valid = 1'b1; sif.s_valid = 1'b1;
                repeat (3) @(negedge clk);
                check({tag, "_post_rst_ready"}, (sel != 0) ? sif.s_ready : bif.s_ready, 1'b0);
                check({tag, "_post_rst_busy"}, (sel != 0) ? s_busy : b_busy, 1'b0);
                check({tag, "_post_rst_chain_rst"}, (sel != 0) ? s_chain_rst : b_chain_rst, 1'b0);
                break;
            end
            if (sel != 0) start_s = (cyc == start_at); else start_b = (cyc == start_at);
            v = !(o_ready && stall > 0);
            if (o_ready && stall > 0) stall--;
            hs_pend = v && o_ready;
            dw = (widx < nw) ? words[widx] : $urandom;
            if (sel != 0) begin sif.s_valid = v; sif.s_data = dw[3:0]; end
            else begin bif.s_valid = v; bif.s_data = dw; end
        end
        if (!aborted) check({tag, "_done_reached"}, o_done, 1'b1);
        start_b = 1'b0; start_s = 1'b0;
        bif.s_valid = 1'b0; sif.s_valid = 1'b0;
    endtask

    int busy_c, rst_c, hs_c;
    logic [25:0] tail;
    logic [4:0]  small_caps;

    initial begin
        rst_b = 1'b1; rst_s = 1'b1;
        start_b = 1'b0; start_s = 1'b0;
        bif.s_valid = 1'b0; bif.s_data = '0;
        sif.s_valid = 1'b0; sif.s_data = '0;
        #1;
        check("reset_chain_rst", b_chain_rst, 1'b1);
        check("reset_chain_clk", b_chain_clk, 1'b0);
        check("reset_chain_data", b_chain_data, 1'b0);
        check("reset_busy", b_busy, 1'b0);
        check("reset_done", b_done, 1'b0);
        check("reset_ready", bif.s_ready, 1'b0);
        check("reset_small_chain_rst", s_chain_rst, 1'b1);
        repeat (2) @(negedge clk);
        rst_b = 1'b0; rst_s = 1'b0;
        @(negedge clk);
        check("idle_chain_rst_drop", b_chain_rst, 1'b0);
        check("idle_busy", b_busy, 1'b0);

        // Golden stream, valid always high.
        rand_bits(CS);
        build_words(CS, WW, 1'b0);
        run_load(0, "full", -1, -1, -1, -1, -1, busy_c, rst_c, hs_c);
        check_caps(0, "full");
        check("full_busy", busy_c, RC + NW + 2 * CS);
        check("full_handshakes", hs_c, NW);
        check("full_rst_pulse", rst_c, RC);
        check("full_done_data_hold", b_chain_data, exp_bits[CS-1]);
        check("full_busy_low", b_busy, 1'b0);

        // Same stream, 5-cycle stalls ahead of words 0, 17 and 47.
        run_load(0, "stall", 0, 17, 47, -1, -1, busy_c, rst_c, hs_c);
        check_caps(0, "stall");
        check("stall_busy", busy_c, RC + NW + 2 * CS + 15);
        check("stall_handshakes", hs_c, NW);

        // Padding: final word upper bits 0x2AAAAAA, padding all ones.
        rand_bits(CS);
        for (int i = 0; i < LB; i++) exp_bits[CS-LB+i] = ((i % 2) == 0);
        build_words(CS, WW, 1'b1);
        run_load(0, "pad", -1, -1, -1, -1, -1, busy_c, rst_c, hs_c);
        check_caps(0, "pad");
        tail = '0;
        if (cap_b.size() == CS) begin
            for (int i = 0; i < 26; i++) tail = {tail[24:0], cap_b[CS-26+i]};
        end
        check("pad_tail_value", tail, 26'h2AAAAAA);
        check("pad_last_word", words[NW-1], 32'hAAAAAABF);

        // start while busy is ignored.
        rand_bits(CS);
        build_words(CS, WW, 1'b0);
        run_load(0, "start_busy", -1, -1, -1, 100, -1, busy_c, rst_c, hs_c);
        check_caps(0, "start_busy");
        check("start_busy_busy", busy_c, RC + NW + 2 * CS);

        // Restart from DONE: fresh chain reset pulse and full reload.
        run_load(0, "restart", -1, -1, -1, -1, -1, busy_c, rst_c, hs_c);
        check_caps(0, "restart");
        check("restart_rst_pulse", rst_c, RC);

        // Asynchronous reset mid-load, then a clean full load.
        run_load(0, "abort", -1, -1, -1, -1, 700, busy_c, rst_c, hs_c);
        rand_bits(CS);
        build_words(CS, WW, 1'b0);
        run_load(0, "after_abort", -1, -1, -1, -1, -1, busy_c, rst_c, hs_c);
        check_caps(0, "after_abort");
        check("after_abort_rst_pulse", rst_c, RC);
        check("after_abort_busy", busy_c, RC + NW + 2 * CS);

        // Tiny loader: 5 bits from words 0xB, 0x8.
        exp_bits.delete();
        exp_bits.push_back(1'b1); exp_bits.push_back(1'b0); exp_bits.push_back(1'b1);
        exp_bits.push_back(1'b1); exp_bits.push_back(1'b1);
        build_words(5, 4, 1'b0);
        run_load(1, "small", -1, -1, -1, -1, -1, busy_c, rst_c, hs_c);
        check_caps(1, "small");
        small_caps = '0;
        if (cap_s.size() == 5) begin
            for (int i = 0; i < 5; i++) small_caps = {small_caps[3:0], cap_s[i]};
        end
        check("small_caps_value", small_caps, 5'b10111);
        check("small_handshakes", hs_c, 2);
        check("small_busy", busy_c, 16);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fpga_config_loader.md
# fpga_config_loader

Serial configuration loader that sits directly upstream of `fpga_top`'s configuration chain. It accepts the bitstream as WORD_W-bit words over a valid/ready stream, serializes exactly CONFIG_SIZE bits, and drives the fabric's chain reset, chain clock and chain data. It replaces the hand-driven `config_rst`/`config_clk`/`config_in` sequencing with a self-timed programmer. It reports `done` once the fabric is fully configured.

## Interface
- `CONFIG_SIZE`, 1530: number of configuration bits in the fabric chain.
- `WORD_W`, 32: input word width.
- `RST_CYCLES`, 4: cycles `chain_rst` is held high before loading.
- `config_clk`  in  1  loader clock; all state is updated on its rising edge.
- `config_rst`  in  1  reset; asynchronous, active-high.
- `start`  in  1  begin a load; sampled only in IDLE or DONE.
- `s_data`  in  WORD_W  bitstream word.
- `s_valid`  in  1  `s_data` valid.
- `s_ready`  out  1  loader accepts a word this cycle.
- `chain_rst`  out  1  drives fabric `config_rst`.
- `chain_clk`  out  1  drives fabric `config_clk` (registered, divide-by-2 while shifting).
- `chain_data`  out  1  drives fabric `config_in`.
- `busy`  out  1  high in RST, FETCH, SHIFT_LO and SHIFT_HI.
- `done`  out  1  level; high in DONE.

## Operation
- Derived constants:
  - NWORDS = ceil(CONFIG_SIZE/WORD_W); 48 at defaults.
  - LAST_BITS = CONFIG_SIZE − (NWORDS−1)·WORD_W; 26 at defaults.
- Bit order:
  - Word bit WORD_W−1 is shifted first.
  - Word 0 carries bitstream bits CONFIG_SIZE−1 downward.
  - In the final word only the upper LAST_BITS bits are shifted; the lower padding bits are discarded.
- IDLE: all outputs low.
  - `start`=1 → RST.
- RST: `chain_rst`=1 for exactly RST_CYCLES cycles, then FETCH.
- FETCH: `s_ready`=1, `chain_clk`=0.
  - On `s_valid && s_ready`, load the word into the shifter and go to SHIFT_LO.
  - Without `s_valid`, stay in FETCH indefinitely. This is not an error: `chain_clk` simply pauses low.
- SHIFT_LO: `chain_data` = current bit, `chain_clk`=0 → SHIFT_HI.
- SHIFT_HI: `chain_clk`=1 (the fabric captures on this rising edge), `chain_data` unchanged.
  - Decrement the remaining-bit counter.
  - If the total bit count has reached CONFIG_SIZE → DONE.
  - Else if the word is exhausted → FETCH.
  - Else shift the word and go to SHIFT_LO.
- DONE: `done`=1, `chain_clk`=0, `chain_data` holds the last bit.
  - `start`=1 → RST, restarting the full load; `done` drops on the same edge.
- `start` while `busy` is ignored.
- `s_valid` is ignored outside FETCH. Surplus words after CONFIG_SIZE bits are not consumed.
- Counters:
  - Bit counter width is $clog2(CONFIG_SIZE+1).
  - Word-bit counter width is $clog2(WORD_W+1).
  - Neither counter wraps; both are reloaded on entry to RST and FETCH respectively.

## Timing
- Reset values: `s_ready`=0, `chain_clk`=0, `chain_data`=0, `busy`=0, `done`=0, `chain_rst`=1. `chain_rst` drops on the first clock edge in IDLE after reset release.
- `config_rst` mid-load: outputs take their reset values immediately (async) and the FSM returns to IDLE. The partially loaded fabric is left as-is until the next start, which pulses `chain_rst` again.
- All outputs are registered; there is no combinational path from inputs to outputs. Exception: `s_ready` is a state decode, but it does not depend on `s_valid`.
- `chain_data` is stable for the whole SHIFT_LO+SHIFT_HI pair: set up one full cycle before the `chain_clk` rise, held one cycle after it.
- With `s_valid` held high, `busy` lasts exactly RST_CYCLES + NWORDS + 2·CONFIG_SIZE cycles (3112 at defaults). Each FETCH costs one bubble cycle.
- Each `s_valid` stall cycle in FETCH adds exactly one cycle.

## Structure
- Package `fpga_cfg_pkg`:
  - FSM state enum: IDLE, RST, FETCH, SHIFT_LO, SHIFT_HI, DONE.
  - Functions computing NWORDS and LAST_BITS from the parameters.
- Sub-module `cfg_word_shifter`: a WORD_W PISO with load and shift enables and an MSB-first serial output.
- The FSM, counters and output registers live in the top module.

## Test plan
- Default parameters, golden 1530-bit stream as 48 words, `s_valid` always high:
  - Sample `chain_data` on each `chain_clk` rise.
  - Required: 1530 captures equal to the stream MSB-first, `busy` 3112 cycles, then `done`=1.
- Same stream with `s_valid` dropped for 5 cycles before words 0, 17 and 47:
  - Identical capture sequence; `busy` 3127 cycles.
- Padding check: final word lower 6 bits set to 1, upper 26 bits = 0x2AAAAAA:
  - Only 26 bits captured from the last word (1010…); no 1s from the padding.
- `start` pulsed at cycle 100 of a load:
  - Ignored; capture count still 1530.
  - A second `start` in DONE produces a fresh `chain_rst` pulse of 4 cycles and a full reload.
- `config_rst` asserted at bit 700:
  - Outputs immediately `chain_rst`=1 and all others 0; `s_ready` stays 0 after release.
  - A new `start` loads all 1530 bits correctly.
- CONFIG_SIZE=5, WORD_W=4, words 0xB, 0x8:
  - Captures 1,0,1,1,1; `s_ready` handshakes exactly twice; `busy` = 4+2+10 = 16 cycles.
